input_frontend: RTL and testbench

Parametrised player-input front end for the Connect-4 game core. Its jobs:
- Synchronise and debounce NUM_CH local buttons, with optional per-channel auto-repeat.
- Synchronise the matching opponent data lines.
- Present both sides as priority one-hot events, aligned to a shared rate tick so that both boards consume moves at the same rate.

---
 rtl/input_pkg.sv | 18 +
 rtl/input_channel.sv | 92 +++++++++
 rtl/input_frontend.sv | 97 +++++++++
 tb/tb_input_frontend.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/input_pkg.sv
// Shared types and helpers for the Connect-4 player-input front end.
package input_pkg;

    localparam int SYNC_STAGES = 2;

    // Auto-repeat counters count rate ticks, not clock cycles.
    typedef logic [7:0] tick_cnt_t;

    function automatic logic [31:0] onehot_hi(input logic [31:0] vec);
        logic [31:0] res;
        res = '0;
        for (int i = 0; i < 32; i++) begin
            if (vec[i]) res = 32'd1 << i;
        end
        return res;
    endfunction

endpackage

// File: rtl/input_channel.sv
// One local button: synchroniser, debounce and optional tick-based auto-repeat.
module input_channel
    import input_pkg::*;
#(
    parameter bit BTN_INV   = 1'b1,
    parameter int DB_CYCLES = 16,
    parameter bit REPEAT_EN = 1'b0,
    parameter int REP_DLY   = 8,
    parameter int REP_PER   = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic tick_i,
    input  logic btn_i,
    output logic level_o,
    output logic press_req_o
);

    localparam int CW = $clog2(DB_CYCLES);
    localparam logic [CW-1:0] DB_LAST = CW'(DB_CYCLES - 2);
    localparam tick_cnt_t DLY_M1 = tick_cnt_t'(REP_DLY - 1);
    localparam tick_cnt_t PER_M1 = tick_cnt_t'(REP_PER - 1);

    if (DB_CYCLES < 2) begin : g_bad_db
        $error("DB_CYCLES must be at least 2");
    end

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   synced;
    logic [CW-1:0]          db_cnt_q, db_cnt_d;
    logic                   level_q, level_d;
    tick_cnt_t              rep_cnt_q, rep_cnt_d;
    logic                   rep_armed_q, rep_armed_d;
    logic                   rep_fire;
    logic                   press_q;

    assign synced = sync_q[SYNC_STAGES-1] ^ BTN_INV;

    // The flip happens on the cycle the counter would reach DB_CYCLES-1.
    always_comb begin
        db_cnt_d = db_cnt_q;
        level_d  = level_q;
        if (synced == level_q) begin
            db_cnt_d = '0;
        end else if (db_cnt_q == DB_LAST) begin
            level_d  = ~level_q;
            db_cnt_d = '0;
        end else begin
            db_cnt_d = db_cnt_q + 1'b1;
        end
    end

    always_comb begin
        rep_cnt_d   = rep_cnt_q;
        rep_armed_d = rep_armed_q;
        rep_fire    = 1'b0;
        if (!REPEAT_EN || !level_q) begin
            rep_cnt_d   = '0;
            rep_armed_d = 1'b0;
        end else if (tick_i) begin
            if (rep_cnt_q >= (rep_armed_q ? PER_M1 : DLY_M1)) begin
                rep_fire    = 1'b1;
                rep_cnt_d   = '0;
                rep_armed_d = 1'b1;
            end else if (rep_cnt_q != '1) begin
                rep_cnt_d = rep_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q      <= {SYNC_STAGES{BTN_INV}};
            db_cnt_q    <= '0;
            level_q     <= 1'b0;
            rep_cnt_q   <= '0;
            rep_armed_q <= 1'b0;
            press_q     <= 1'b0;
        end else begin
            sync_q      <= {sync_q[SYNC_STAGES-2:0], btn_i};
            db_cnt_q    <= db_cnt_d;
            level_q     <= level_d;
            rep_cnt_q   <= rep_cnt_d;
            rep_armed_q <= rep_armed_d;
            press_q     <= (level_d & ~level_q) | rep_fire;
        end
    end

    assign level_o     = level_q;
    assign press_req_o = press_q;

endmodule

// File: rtl/input_frontend.sv
// Player-input front end: local and remote moves as priority one-hot events
// aligned to a shared rate tick.
module input_frontend
    import input_pkg::*;
#(
    parameter int                NUM_CH      = 3,
    parameter bit                BTN_INV     = 1'b1,
    parameter int                DB_CYCLES   = 16,
    parameter int                TICK_W      = 6,
    parameter logic [NUM_CH-1:0] REPEAT_MASK = '0,
    parameter int                REP_DLY     = 8,
    parameter int                REP_PER     = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_CH-1:0] btn_in,
    input  logic [NUM_CH-1:0] remote_in,
    output logic [NUM_CH-1:0] btn_level,
    output logic              tick,
    output logic [NUM_CH-1:0] self_evt,
    output logic [NUM_CH-1:0] remote_evt
);

    if (REP_DLY < 1 || REP_DLY > 255) begin : g_bad_dly
        $error("REP_DLY must be in 1..255");
    end
    if (REP_PER < 1 || REP_PER > 255) begin : g_bad_per
        $error("REP_PER must be in 1..255");
    end

    logic [TICK_W-1:0]                  tcnt_q;
    logic [NUM_CH-1:0]                  level;
    logic [NUM_CH-1:0]                  press_req;
    logic [NUM_CH-1:0]                  pend_q, pend_d;
    logic [NUM_CH-1:0]                  self_q, self_d;
    logic [NUM_CH-1:0]                  remote_q, remote_d;
    logic [SYNC_STAGES-1:0][NUM_CH-1:0] rsync_q;
    logic [NUM_CH-1:0]                  rprev_q;
    logic [NUM_CH-1:0]                  rsynced;
    logic                               r_rise;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        input_channel #(
            .BTN_INV   (BTN_INV),
            .DB_CYCLES (DB_CYCLES),
            .REPEAT_EN (REPEAT_MASK[i]),
            .REP_DLY   (REP_DLY),
            .REP_PER   (REP_PER)
        ) u_ch (
            .clk         (clk),
            .rst         (rst),
            .tick_i      (tick),
            .btn_i       (btn_in[i]),
            .level_o     (level[i]),
            .press_req_o (press_req[i])
        );
    end

    assign tick    = &tcnt_q;
    assign rsynced = rsync_q[SYNC_STAGES-1];
    assign r_rise  = |(rsynced & ~rprev_q);

    // Requests arriving on the tick cycle survive into the next window.
    always_comb begin
        pend_d   = tick ? press_req : (pend_q | press_req);
        self_d   = tick ? NUM_CH'(onehot_hi(32'(pend_q))) : self_q;
        remote_d = remote_q;
        if (r_rise) begin
            remote_d = NUM_CH'(onehot_hi(32'(rsynced)));
        end else if (tick) begin
            remote_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tcnt_q   <= '0;
            pend_q   <= '0;
            self_q   <= '0;
            remote_q <= '0;
            rsync_q  <= '0;
            rprev_q  <= '0;
        end else begin
            tcnt_q   <= tcnt_q + 1'b1;
            pend_q   <= pend_d;
            self_q   <= self_d;
            remote_q <= remote_d;
            rsync_q  <= {rsync_q[SYNC_STAGES-2:0], remote_in};
            rprev_q  <= rsynced;
        end
    end

    assign btn_level  = level;
    assign self_evt   = self_q;
    assign remote_evt = remote_q;

endmodule

// File: tb/tb_input_frontend.sv
// Scoreboard bench for input_frontend: a cycle-level reference model pushes
// expected outputs into a queue that a separate monitor drains and checks.
module tb_input_frontend;

    localparam int         N     = 3;
    localparam int         DB    = 4;
    localparam int         TW    = 3;
    localparam int         TPER  = 1 << TW;
    localparam logic [2:0] RMASK = 3'b011;
    localparam int         DLY   = 2;
    localparam int         PER   = 1;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] btn_in = 3'b111;
    logic [2:0] remote_in = 3'b000;
    logic [2:0] btn_level, self_evt, remote_evt;
    logic       tick;

    input_frontend #(
        .NUM_CH(N), .BTN_INV(1'b1), .DB_CYCLES(DB), .TICK_W(TW),
        .REPEAT_MASK(RMASK), .REP_DLY(DLY), .REP_PER(PER)
    ) dut (
        .clk(clk), .rst(rst), .btn_in(btn_in), .remote_in(remote_in),
        .btn_level(btn_level), .tick(tick), .self_evt(self_evt), .remote_evt(remote_evt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0] lvl;
        logic       tk;
        logic [2:0] self_e;
        logic [2:0] rem_e;
    } exp_t;

    exp_t exp_q[$];
    event push_ev;
    int   vectors = 0;
    int   miscompares = 0;

    // Reference model state (values visible after the most recent clock edge)
    logic [2:0] raw_h[$];
    logic [2:0] rem_h[$];
    logic [2:0] shist[$];
    logic [2:0] m_level, m_self, m_remote, m_pend, m_req, m_rprev;
    int         m_tcnt;
    int         held[3];
    logic [2:0] cur_btn = 3'b111, cur_rem = 3'b000;

    function automatic logic [2:0] hi1(input logic [2:0] v);
        if (v[2]) return 3'b100;
        if (v[1]) return 3'b010;
        if (v[0]) return 3'b001;
        return 3'b000;
    endfunction

    task automatic model_reset();
        raw_h    = '{3'b111, 3'b111};
        rem_h    = '{3'b000, 3'b000};
        shist.delete();
        m_level  = '0; m_self = '0; m_remote = '0;
        m_pend   = '0; m_req = '0;  m_rprev = '0;
        m_tcnt   = 0;
        held     = '{0, 0, 0};
    endtask

    task automatic model_step(input logic [2:0] b, input logic [2:0] r);
        logic [2:0] lvl_old, new_lvl, sb, rs, rise, fire;
        logic       tk;
        bit         all_diff;
        lvl_old = m_level;
        tk      = (m_tcnt == TPER - 1);
        // buttons appear two edges late, inverted to active-high
        sb = raw_h[0] ^ 3'b111;
        raw_h.delete(0);
        raw_h.push_back(b);
        shist.push_back(sb);
        if (shist.size() > DB - 1) shist.delete(0);
        new_lvl = lvl_old;
        for (int i = 0; i < 3; i++) begin
            all_diff = (shist.size() == DB - 1);
            foreach (shist[j]) if (shist[j][i] == lvl_old[i]) all_diff = 0;
            if (all_diff) new_lvl[i] = ~lvl_old[i];
        end
        rise = new_lvl & ~lvl_old;
        fire = 3'b000;
        for (int i = 0; i < 3; i++) begin
            if (RMASK[i]) begin
                if (!lvl_old[i]) held[i] = 0;
                else if (tk) begin
                    held[i]++;
                    if (held[i] == DLY || (held[i] > DLY && (held[i] - DLY) % PER == 0))
                        fire[i] = 1'b1;
                end
            end
        end
        if (tk) begin
            m_self = hi1(m_pend);
            m_pend = m_req;
        end else begin
            m_pend = m_pend | m_req;
        end
        m_req   = rise | fire;
        m_level = new_lvl;
        m_tcnt  = (m_tcnt + 1) % TPER;
        rs = rem_h[0];
        rem_h.delete(0);
        rem_h.push_back(r);
        if (|(rs & ~m_rprev)) m_remote = hi1(rs);
        else if (tk) m_remote = 3'b000;
        m_rprev = rs;
    endtask

    task automatic push_exp();
        exp_t e;
        e.lvl    = m_level;
        e.tk     = (m_tcnt == TPER - 1);
        e.self_e = m_self;
        e.rem_e  = m_remote;
        exp_q.push_back(e);
        -> push_ev;
    endtask

    task automatic step(input logic [2:0] b, input logic [2:0] r);
        btn_in = b; remote_in = r;
        cur_btn = b; cur_rem = r;
        @(posedge clk);
        if (rst) model_reset();
        else model_step(b, r);
        #1;
        push_exp();
    endtask

    task automatic hold(input logic [2:0] b, input logic [2:0] r, input int n);
        repeat (n) step(b, r);
    endtask

    // Asserted mid-cycle so the check lands before the next clock edge.
    task automatic async_reset(input int n);
        #4;
        rst = 1'b1;
        model_reset();
        push_exp();
        repeat (n) step(cur_btn, cur_rem);
        rst = 1'b0;
    endtask

    task automatic chk(input string nm, input logic [2:0] act, input logic [2:0] ex);
        if (act !== ex) begin
            miscompares++;
            $display("FAIL %s at %0t: got %b, expected %b", nm, $time, act, ex);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(push_ev);
            #2;
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                vectors++;
                chk("btn_level", btn_level, e.lvl);
                chk("tick", {2'b00, tick}, {2'b00, e.tk});
                chk("self_evt", self_evt, e.self_e);
                chk("remote_evt", remote_evt, e.rem_e);
            end
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: time limit reached, %0d vectors checked", vectors);
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        logic [2:0] b, r;
        model_reset();
        hold(3'b111, 3'b000, 3);
        rst = 1'b0;
        hold(3'b111, 3'b000, 10);
        // clean press on put
        hold(3'b110, 3'b000, 40);
        hold(3'b111, 3'b000, 30);
        // bouncing right button
        for (int k = 0; k < 5; k++) begin
            hold(3'b101, 3'b000, 2);
            hold(3'b111, 3'b000, 2);
        end
        hold(3'b111, 3'b000, 20);
        // left and right in the same window
        hold(3'b011, 3'b000, 1);
        hold(3'b001, 3'b000, 20);
        hold(3'b111, 3'b000, 30);
        // auto-repeat on put, none on left
        hold(3'b110, 3'b000, 60);
        hold(3'b111, 3'b000, 30);
        hold(3'b011, 3'b000, 60);
        hold(3'b111, 3'b000, 30);
        // remote pulses at every tick phase, then a held level
        for (int ph = 0; ph < TPER; ph++) begin
            hold(3'b111, 3'b000, ph);
            hold(3'b111, 3'b011, 1);
            hold(3'b111, 3'b000, 12);
        end
        hold(3'b111, 3'b100, 30);
        hold(3'b111, 3'b000, 5);
        // reset while put is held and its event is showing
        hold(3'b110, 3'b000, 20);
        async_reset(2);
        hold(3'b110, 3'b000, 30);
        hold(3'b111, 3'b000, 20);
        // random traffic
        b = 3'b111;
        r = 3'b000;
        for (int k = 0; k < 3000; k++) begin
            for (int c = 0; c < 3; c++)
                if ($urandom_range(0, 15) == 0) b[c] = ~b[c];
            if ($urandom_range(0, 5) == 0) r = 3'($urandom);
            if (k % 997 == 500) async_reset(1 + k % 3);
            step(b, r);
        end
        hold(3'b111, 3'b000, 4);
        #5;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_drain: got %0d unchecked entries, expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
